// File: rtl/util_wr_sync_pkg.sv
// Shared constants for the write-sync arbiter.
//   MODE_*  : values of the 2-bit mode input (3 is reserved and treated as LEVEL)
//   state_e : one-shot FSM encoding
package util_wr_sync_pkg;

  localparam logic [1:0] MODE_LEVEL   = 2'd0;
  localparam logic [1:0] MODE_PULSE   = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;

  localparam logic [15:0] EVT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_e;

endpackage

// File: rtl/util_wr_sync_cdc.sv
// Single-bit multi-flop synchroniser for an asynchronous sync source.
//   clk, rst : destination clock, async active-high reset (chain clears to 0)
//   d        : raw asynchronous input
//   q        : synchronised output, STAGES cycles behind d
module util_wr_sync_cdc
  import util_wr_sync_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/util_wr_sync_arb.sv
// Write-sync source arbiter: picks one of NUM_SRC sync sources (source 0 is
// the timestamp generator and wins whenever timestamp_every is nonzero),
// synchronises the async ones, and produces a registered level / pulse /
// one-shot output with holdoff and a saturating event counter.
//   clk, rst        : clock, async active-high reset
//   timestamp_every : nonzero forces source 0
//   src_sel         : source index otherwise
//   mode            : LEVEL / PULSE / ONESHOT (3 behaves as LEVEL)
//   arm             : strobe that arms the one-shot
//   holdoff         : cycles after a qualifying edge during which edges are ignored
//   sync_in         : raw sources
//   sync_out        : registered sync to the DMA
//   sync_pulse      : one-cycle strobe per qualifying edge
//   armed           : one-shot waiting for an edge
//   event_count     : saturating count of qualifying edges
module util_wr_sync_arb
  import util_wr_sync_pkg::*;
#(
  parameter int                  NUM_SRC     = 4,
  parameter int                  SEL_W       = 2,
  parameter logic [NUM_SRC-1:0]  ASYNC_MASK  = 4'b1110,
  parameter int                  SYNC_STAGES = 2,
  parameter int                  HOLDOFF_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          timestamp_every,
  input  logic [SEL_W-1:0]     src_sel,
  input  logic [1:0]           mode,
  input  logic                 arm,
  input  logic [HOLDOFF_W-1:0] holdoff,
  input  logic [NUM_SRC-1:0]   sync_in,
  output logic                 sync_out,
  output logic                 sync_pulse,
  output logic                 armed,
  output logic [15:0]          event_count
);

  localparam int PAD_W = 2 ** SEL_W;

  // ---------------------------------------------------------------- input stage
  logic [NUM_SRC-1:0] in_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic q_i;
    if (ASYNC_MASK[i]) begin : g_async
      util_wr_sync_cdc #(.STAGES(SYNC_STAGES)) u_cdc (
        .clk (clk),
        .rst (rst),
        .d   (sync_in[i]),
        .q   (q_i)
      );
    end else begin : g_sync
      always_ff @(posedge clk or posedge rst) begin
        if (rst) q_i <= 1'b0;
        else     q_i <= sync_in[i];
      end
    end
    assign in_q[i] = q_i;
  end

  // ---------------------------------------------------------------- selection
  logic [SEL_W-1:0] eff_sel, sel_q, sel_prev;
  logic [1:0]       mode_q;
  logic [PAD_W-1:0] in_pad;
  logic             selected, sel_chg, mode_chg;

  assign eff_sel = (timestamp_every != 32'd0) ? '0 : src_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q    <= '0;
      sel_prev <= '0;
      mode_q   <= MODE_LEVEL;
    end else begin
      sel_q    <= eff_sel;
      sel_prev <= sel_q;
      mode_q   <= mode;
    end
  end

  // Zero-padding to the full select range makes indices >= NUM_SRC read 0.
  always_comb begin
    in_pad              = '0;
    in_pad[NUM_SRC-1:0] = in_q;
  end

  assign selected = in_pad[sel_q];
  assign sel_chg  = (sel_q != sel_prev);
  assign mode_chg = (mode != mode_q);

  // ---------------------------------------------------------------- edge detect
  logic                 prev;
  logic [HOLDOFF_W-1:0] hold_cnt;
  logic                 qual;

  assign qual = selected && !prev && (hold_cnt == '0) && !sel_chg;

  // prev always follows the selected source, so on a selection change it is
  // loaded with the new source's level and an already-high input is no edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      prev <= selected;
      if (sel_chg)             hold_cnt <= '0;
      else if (qual)           hold_cnt <= holdoff;
      else if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // ---------------------------------------------------------------- one-shot FSM
  state_e state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // arm takes priority over an edge in IDLE and FIRED.
  always_comb begin
    state_nxt = state;
    if (mode != MODE_ONESHOT || mode_chg || sel_chg) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (arm)  state_nxt = ST_ARMED;
        ST_ARMED: if (qual) state_nxt = ST_FIRED;
        ST_FIRED: if (arm)  state_nxt = ST_ARMED;
        default:            state_nxt = ST_IDLE;
      endcase
    end
  end

  assign armed = (state == ST_ARMED);

  // ---------------------------------------------------------------- outputs
  logic out_nxt;

  always_comb begin
    out_nxt = 1'b0;
    if (!sel_chg && !mode_chg) begin
      case (mode)
        MODE_PULSE:   out_nxt = qual;
        MODE_ONESHOT: out_nxt = (state_nxt == ST_FIRED);
        default:      out_nxt = selected;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_out    <= 1'b0;
      sync_pulse  <= 1'b0;
      event_count <= '0;
    end else begin
      sync_out   <= out_nxt;
      sync_pulse <= qual;
      if (qual && event_count != EVT_MAX)
        event_count <= event_count + 16'd1;
    end
  end

endmodule
